// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, FSM states,
// control-field codes and the packed control word.
package cpu_ctrl_pkg;

   localparam logic [3:0] OP_RTYPE  = 4'h0;
   localparam logic [3:0] OP_BR_LO  = 4'h3;
   localparam logic [3:0] OP_BR_HI  = 4'h5;
   localparam logic [3:0] OP_IMM_LO = 4'h8;
   localparam logic [3:0] OP_IMM_HI = 4'hB;
   localparam logic [3:0] OP_LOAD   = 4'hC;
   localparam logic [3:0] OP_STORE  = 4'hD;
   localparam logic [3:0] OP_JUMP   = 4'hE;
   localparam logic [3:0] OP_HALT   = 4'hF;

   localparam logic [3:0] FN_NOP = 4'h0;
   localparam logic [3:0] FN_MUL = 4'h1;
   localparam logic [3:0] FN_DIV = 4'h2;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5
   } state_t;

   localparam logic [1:0] RW_NONE   = 2'd0;
   localparam logic [1:0] RW_OP1    = 2'd1;
   localparam logic [1:0] RW_OP1_R0 = 2'd2;
   localparam logic [1:0] RW_CMP    = 2'd3;

   localparam logic [1:0] EX_ZERO8 = 2'd0;
   localparam logic [1:0] EX_SIGN8 = 2'd1;
   localparam logic [1:0] EX_SIGN4 = 2'd2;

   localparam logic [1:0] MW_IDLE  = 2'd0;
   localparam logic [1:0] MW_WRITE = 2'd1;
   localparam logic [1:0] MW_READ  = 2'd2;

   typedef struct packed {
      logic       alu_src_a;
      logic       alu_src_b;
      logic       mem_to_reg;
      logic       jump;
      logic       branch;
      logic [1:0] reg_write;
      logic [1:0] ex_sign;
      logic [1:0] mem_write;
      logic [3:0] alu_op;
   } ctrl_word_t;

   localparam int CW_W = $bits(ctrl_word_t);

   // Idle datapath word: register operands, ALU result, sequential PC.
   localparam ctrl_word_t CW_RESET = '{
      alu_src_a:  1'b1,
      alu_src_b:  1'b1,
      mem_to_reg: 1'b1,
      jump:       1'b1,
      branch:     1'b0,
      reg_write:  RW_NONE,
      ex_sign:    EX_ZERO8,
      mem_write:  MW_IDLE,
      alu_op:     4'hF
   };

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: opcode/funct to datapath control word,
// plus an indicator for undefined opcodes.
module ctrl_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [15:0]     instr,
   output logic [CW_W-1:0] cw,
   output logic            illegal_op
);

   logic [3:0] opcode;
   logic [3:0] funct;
   logic       unused_fields;
   ctrl_word_t w;

   assign opcode        = instr[15:12];
   assign funct         = instr[3:0];
   assign unused_fields = ^instr[11:4];

   always_comb begin
      w          = CW_RESET;
      illegal_op = 1'b0;
      if (opcode == OP_RTYPE) begin
         w.alu_op = funct;
         if (funct == FN_NOP)
            w.reg_write = RW_NONE;
         else if (funct == FN_MUL || funct == FN_DIV)
            w.reg_write = RW_OP1_R0;
         else
            w.reg_write = RW_OP1;
      end else if (opcode inside {[OP_IMM_LO:OP_IMM_HI]}) begin
         w.alu_op    = opcode;
         w.alu_src_b = 1'b0;
         w.ex_sign   = EX_SIGN8;
         w.reg_write = RW_OP1;
      end else if (opcode inside {[OP_BR_LO:OP_BR_HI]}) begin
         w.alu_op    = opcode;
         w.branch    = 1'b1;
         w.reg_write = RW_CMP;
      end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
         // Address = base register + sign-extended 4-bit offset.
         w.alu_src_a  = 1'b0;
         w.alu_src_b  = 1'b0;
         w.ex_sign    = EX_SIGN4;
         w.alu_op     = 4'hF;
         w.mem_to_reg = 1'b0;
         w.mem_write  = (opcode == OP_LOAD) ? MW_READ : MW_WRITE;
         w.reg_write  = (opcode == OP_LOAD) ? RW_OP1 : RW_NONE;
      end else if (opcode == OP_JUMP) begin
         w.jump = 1'b0;
      end else if (opcode != OP_HALT) begin
         illegal_op = 1'b1;
      end
   end

   assign cw = w;

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle instruction sequencer driving the datapath control inputs from
// a control word registered at decode time.
//
//   state  | meaning
//   FETCH  | load IR, advance PC
//   DECODE | decode instr, capture control word
//   EXEC   | ALU operation; compare-only writes enabled
//   MEM    | data memory access, bounded by MEM_TIMEOUT
//   WB     | register write-back, commit strobe
//   HALT   | absorbing until reset
module control_fsm
   import cpu_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] instr,
   input  logic        mem_ready,
   output logic        ir_load,
   output logic        pc_write,
   output logic        AluScrA,
   output logic        AluSrcB,
   output logic        memToReg,
   output logic        jump,
   output logic        branch,
   output logic [1:0]  regWrite,
   output logic [1:0]  exSign,
   output logic [1:0]  memWrite,
   output logic [3:0]  Aluop,
   output logic        nest,
   output logic        halted,
   output logic        illegal
);

   localparam int TW = $clog2(MEM_TIMEOUT + 1);

   state_t          state, state_nx;
   ctrl_word_t      cw_q, cw_dec;
   logic [CW_W-1:0] cw_dec_bits;
   logic            illegal_op;
   logic [TW-1:0]   tmr;
   logic            tmr_tc;
   logic            timed_out;
   logic            illegal_q;

   ctrl_decode u_decode (
      .instr      (instr),
      .cw         (cw_dec_bits),
      .illegal_op (illegal_op)
   );

   assign cw_dec = ctrl_word_t'(cw_dec_bits);
   assign tmr_tc = (tmr == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= FETCH;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         FETCH:   state_nx = DECODE;
         DECODE:  state_nx = (instr[15:12] == OP_HALT) ? HALT : EXEC;
         EXEC:    state_nx = (cw_q.mem_write != MW_IDLE) ? MEM : WB;
         MEM:     if (mem_ready || tmr_tc) state_nx = WB;
         WB:      state_nx = FETCH;
         HALT:    state_nx = HALT;
         default: state_nx = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cw_q      <= CW_RESET;
         tmr       <= '0;
         timed_out <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         if (state == DECODE && state_nx == EXEC) begin
            cw_q      <= cw_dec;
            timed_out <= 1'b0;
            if (illegal_op)
               illegal_q <= 1'b1;
         end
         // Terminal count on the last permitted low cycle forces WB.
         if (state == EXEC)
            tmr <= TW'(MEM_TIMEOUT - 1);
         else if (state == MEM && !mem_ready && !tmr_tc)
            tmr <= tmr - TW'(1);
         if (state == MEM && !mem_ready && tmr_tc) begin
            timed_out <= 1'b1;
            illegal_q <= 1'b1;
         end
      end
   end

   always_comb begin
      ir_load  = (state == FETCH);
      pc_write = (state == FETCH);
      nest     = (state == WB);
      halted   = (state == HALT);
      illegal  = illegal_q;
      AluScrA  = cw_q.alu_src_a;
      AluSrcB  = cw_q.alu_src_b;
      memToReg = cw_q.mem_to_reg;
      jump     = cw_q.jump;
      branch   = cw_q.branch;
      exSign   = cw_q.ex_sign;
      Aluop    = cw_q.alu_op;
      regWrite = RW_NONE;
      if (state == WB && !timed_out)
         regWrite = cw_q.reg_write;
      else if (state == EXEC && cw_q.reg_write == RW_CMP)
         regWrite = RW_CMP;
      memWrite = (state == MEM) ? cw_q.mem_write : MW_IDLE;
   end

endmodule
